// File: rtl/irq_trap_ctrl.sv
// Machine-mode external-interrupt and trap-return sequencer.
// Synchronizes ext_irq into meip, and when the interrupt is enabled and a real
// instruction is available it saves the return PC, writes mepc/mcause, updates
// mstatus through the CSR side-ports and redirects fetch to the mtvec target.
// MRET in IDLE redirects to mepc and restores mstatus in the same cycle.
module irq_trap_ctrl #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int IRQ_CODE    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_irq,
  input  logic              mstatus_mie,
  input  logic              mie_meie,
  input  logic [DATA_W-1:0] mtvec,
  input  logic [DATA_W-1:0] mepc_in,
  input  logic [DATA_W-1:0] pc_cur,
  input  logic              pc_valid,
  input  logic              stall,
  input  logic              mret,
  output logic              meip,
  output logic              mepc_we,
  output logic [DATA_W-1:0] mepc_wdata,
  output logic              mcause_we,
  output logic [DATA_W-1:0] mcause_wdata,
  output logic              mstatus_trap,
  output logic              mstatus_mret,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              busy
);

  // Interrupt bit set plus the exception code in the low bits.
  localparam logic [DATA_W-1:0] MCAUSE_VAL = {1'b1, (DATA_W-1)'(IRQ_CODE)};
  // Vectored-mode offset from the trap base for this interrupt.
  localparam logic [DATA_W-1:0] VEC_OFF    = DATA_W'(4 * IRQ_CODE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SAVE  = 2'd2,
    ST_REDIR = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic [DATA_W-1:0]      epc_r;
  logic                   epc_load_s;
  logic                   irq_en_s;
  logic                   take_s;
  logic                   mret_fire_s;
  logic [DATA_W-1:0]      tvec_base_s;
  logic [DATA_W-1:0]      tvec_target_s;

  assign meip = sync_r[SYNC_STAGES-1];

  // Shift the asynchronous request through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ext_irq};
    end
  end

  // Request is pending and enabled; WAIT re-checks only this part.
  assign irq_en_s = meip & mstatus_mie & mie_meie;
  assign take_s   = irq_en_s & pc_valid;

  // MRET is honoured only from IDLE; while a trap is in flight the redirect flushes it.
  assign mret_fire_s = (state_r == ST_IDLE) & mret & ~stall & ~rst;

  // Modes 2 and 3 fall back to direct; only mode 1 adds the vector offset.
  assign tvec_base_s   = {mtvec[DATA_W-1:2], 2'b00};
  assign tvec_target_s = (mtvec[1:0] == 2'b01) ? (tvec_base_s + VEC_OFF) : tvec_base_s;

  // State register and saved return PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      epc_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (epc_load_s) begin
        epc_r <= pc_cur;
      end else begin
        epc_r <= epc_r;
      end
    end
  end

  // Next-state selection and return-PC capture.
  always_comb begin
    state_nxt_s = state_r;
    epc_load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mret_fire_s) begin
          state_nxt_s = ST_IDLE;
        end else if (take_s && !stall) begin
          epc_load_s  = 1'b1;
          state_nxt_s = ST_SAVE;
        end else if (take_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!irq_en_s) begin
          state_nxt_s = ST_IDLE;
        end else if (!stall && pc_valid) begin
          epc_load_s  = 1'b1;
          state_nxt_s = ST_SAVE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_SAVE: begin
        state_nxt_s = ST_REDIR;
      end
      ST_REDIR: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Side-port pulses and redirect, decoded from the registered state.
  always_comb begin
    mepc_we      = 1'b0;
    mepc_wdata   = '0;
    mcause_we    = 1'b0;
    mcause_wdata = '0;
    mstatus_trap = 1'b0;
    mstatus_mret = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    busy         = (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (mret_fire_s) begin
          redirect     = 1'b1;
          redirect_pc  = mepc_in;
          mstatus_mret = 1'b1;
        end else begin
          redirect     = 1'b0;
        end
      end
      ST_SAVE: begin
        mepc_we      = 1'b1;
        mepc_wdata   = epc_r;
        mcause_we    = 1'b1;
        mcause_wdata = MCAUSE_VAL;
        mstatus_trap = 1'b1;
      end
      ST_REDIR: begin
        redirect    = 1'b1;
        redirect_pc = tvec_target_s;
      end
      default: begin
        redirect = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
module tb_irq_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq;
  logic        mstatus_mie;
  logic        mie_meie;
  logic [31:0] mtvec;
  logic [31:0] mepc_in;
  logic [31:0] pc_cur;
  logic        pc_valid;
  logic        stall;
  logic        mret;
  logic        meip;
  logic        mepc_we;
  logic [31:0] mepc_wdata;
  logic        mcause_we;
  logic [31:0] mcause_wdata;
  logic        mstatus_trap;
  logic        mstatus_mret;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  irq_trap_ctrl #(.DATA_W(32), .SYNC_STAGES(2), .IRQ_CODE(11)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .mstatus_mie(mstatus_mie),
    .mie_meie(mie_meie), .mtvec(mtvec), .mepc_in(mepc_in), .pc_cur(pc_cur),
    .pc_valid(pc_valid), .stall(stall), .mret(mret), .meip(meip),
    .mepc_we(mepc_we), .mepc_wdata(mepc_wdata), .mcause_we(mcause_we),
    .mcause_wdata(mcause_wdata), .mstatus_trap(mstatus_trap),
    .mstatus_mret(mstatus_mret), .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Everything that must be quiet outside SAVE/REDIRECT/MRET cycles.
  task automatic chk_quiet(input string tag);
    chk({tag, ".we"},  {29'd0, mepc_we, mcause_we, mstatus_trap}, 32'd0);
    chk({tag, ".red"}, {30'd0, redirect, mstatus_mret}, 32'd0);
  endtask

  // From SAVE onward: check the writes, clear MIE as the CSR would, check the redirect.
  task automatic finish_trap(input string tag, input logic [31:0] epc, input logic [31:0] tgt);
    chk({tag, ".mepc_we"},  {31'd0, mepc_we}, 32'd1);
    chk({tag, ".mepc"},     mepc_wdata, epc);
    chk({tag, ".mcause"},   {mcause_wdata[31:1], mcause_we}, 32'h8000_000B);
    chk({tag, ".trap"},     {31'd0, mstatus_trap}, 32'd1);
    chk({tag, ".busy"},     {31'd0, busy}, 32'd1);
    mstatus_mie = 1'b0;
    tick();
    chk({tag, ".redirect"}, {31'd0, redirect}, 32'd1);
    chk({tag, ".rpc"},      redirect_pc, tgt);
    chk({tag, ".nowe"},     {31'd0, mepc_we}, 32'd0);
    tick();
    chk({tag, ".idle"},     {31'd0, busy}, 32'd0);
    chk_quiet({tag, ".after"});
  endtask

  initial begin
    rst = 1'b1; ext_irq = 1'b1; mstatus_mie = 1'b0; mie_meie = 1'b0;
    mtvec = 32'h0000_1000; mepc_in = 32'd0; pc_cur = 32'h0000_0240;
    pc_valid = 1'b1; stall = 1'b0; mret = 1'b0;

    // Reset with the request already high.
    tick(); tick();
    chk("rst.meip", {31'd0, meip}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk_quiet("rst");
    chk("rst.data", mepc_wdata | mcause_wdata | redirect_pc, 32'd0);
    rst = 1'b0;
    tick();
    chk("sync.edge1", {31'd0, meip}, 32'd0);
    tick();
    chk("sync.edge2", {31'd0, meip}, 32'd1);

    // Basic direct-mode trap.
    mstatus_mie = 1'b1; mie_meie = 1'b1;
    settle();
    chk("basic.pre", {31'd0, busy}, 32'd0);
    tick();
    finish_trap("basic", 32'h0000_0240, 32'h0000_1000);

    // Vectored mode, normal and wrapping.
    mtvec = 32'h0000_1001; pc_cur = 32'h0000_0250; mstatus_mie = 1'b1;
    tick();
    finish_trap("vec", 32'h0000_0250, 32'h0000_102C);
    mtvec = 32'hFFFF_FFF1; pc_cur = 32'h0000_0260; mstatus_mie = 1'b1;
    tick();
    finish_trap("wrap", 32'h0000_0260, 32'h0000_001C);

    // Stall held 5 cycles: wait without writing, then trap with the later PC.
    mtvec = 32'h0000_1000; mstatus_mie = 1'b1; stall = 1'b1; pc_cur = 32'h0000_0300;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall.busy", {31'd0, busy}, 32'd1);
      chk_quiet("stall");
      pc_cur = 32'h0000_0304 + 32'(i * 4);
    end
    stall = 1'b0;
    tick();
    finish_trap("stall", 32'h0000_0314, 32'h0000_1000);

    // Request withdrawn while waiting.
    mstatus_mie = 1'b1; stall = 1'b1;
    tick();
    chk("wd.wait", {31'd0, busy}, 32'd1);
    mstatus_mie = 1'b0;
    tick();
    chk("wd.idle", {31'd0, busy}, 32'd0);
    chk_quiet("wd.idle");
    stall = 1'b0;
    tick();
    chk("wd.stay", {31'd0, busy}, 32'd0);
    chk_quiet("wd.stay");

    // MRET alone.
    mepc_in = 32'h0000_0244; mret = 1'b1;
    settle();
    chk("mret.red",  {31'd0, redirect}, 32'd1);
    chk("mret.rpc",  redirect_pc, 32'h0000_0244);
    chk("mret.mret", {31'd0, mstatus_mret}, 32'd1);
    tick();
    mret = 1'b0;
    settle();
    chk("mret.busy", {31'd0, busy}, 32'd0);

    // MRET and take together: MRET first, trap on the following cycles.
    mstatus_mie = 1'b1; mret = 1'b1; pc_cur = 32'h0000_0400;
    settle();
    chk("both.rpc",  redirect_pc, 32'h0000_0244);
    chk("both.mret", {31'd0, mstatus_mret}, 32'd1);
    chk("both.nowe", {31'd0, mepc_we}, 32'd0);
    tick();
    mret = 1'b0; pc_cur = 32'h0000_0244;
    chk("both.idle", {31'd0, busy}, 32'd0);
    tick();
    mret = 1'b1;
    settle();
    chk("busy.mret_ign", {31'd0, mstatus_mret}, 32'd0);
    mret = 1'b0;
    finish_trap("both", 32'h0000_0244, 32'h0000_1000);

    // Masked by MEIE for 20 cycles, then enabled.
    mie_meie = 1'b0; mstatus_mie = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 5 == 0) begin
        chk("mask.meip", {31'd0, meip}, 32'd1);
        chk("mask.busy", {31'd0, busy}, 32'd0);
        chk_quiet("mask");
      end
    end
    mie_meie = 1'b1; pc_cur = 32'h0000_0500;
    tick();
    finish_trap("unmask", 32'h0000_0500, 32'h0000_1000);

    // Reset during SAVE abandons the sequence.
    mstatus_mie = 1'b1; pc_cur = 32'h0000_0600;
    tick();
    chk("mid.save", {31'd0, mepc_we}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid.busy", {31'd0, busy}, 32'd0);
    chk_quiet("mid.rst");
    rst = 1'b0;
    tick();
    chk("mid.after", {30'd0, redirect, meip}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
